// File: rtl/fifo_serial_drain.sv
// Read-side companion to a byte FIFO: pops one entry at a time and shifts it
// out on a single line as an async serial frame (start, LSB-first data, stop).
module fifo_serial_drain #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              byte_done,
  output logic [7:0]        frame_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              bit_end;

  assign bit_end = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // bit_cnt is shared: it walks the data bits in DATA, then the stop bits in STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx          <= 1'b1;
      fifo_rd_en  <= 1'b0;
      busy        <= 1'b0;
      byte_done   <= 1'b0;
      frame_count <= 8'd0;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (en && !fifo_empty) begin
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
            state      <= POP;
          end
        end
        POP: begin
          fifo_rd_en <= 1'b0;
          state      <= LATCH;
        end
        LATCH: begin
          shreg   <= fifo_rd_data;
          tx      <= 1'b0;
          clk_cnt <= '0;
          bit_cnt <= '0;
          state   <= START;
        end
        START: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) begin
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              tx      <= 1'b1;
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) begin
            if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
              bit_cnt     <= '0;
              busy        <= 1'b0;
              byte_done   <= 1'b1;
              frame_count <= frame_count + 8'd1;
              state       <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx         <= 1'b1;
          fifo_rd_en <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
